// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: serializes a parallel word LSB first, computes parity,
// and steers the select/enable of the 4:1 TX line mux. One bit per baud-rate clock.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  SER_DATA,
   output logic                  PAR_BIT,
   output logic [1:0]            MUX_SEL,
   output logic                  MUX_EN,
   output logic                  BUSY,
   output logic                  TX_DONE
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   localparam logic [1:0] SEL_START  = 2'b00;
   localparam logic [1:0] SEL_DATA   = 2'b01;
   localparam logic [1:0] SEL_PARITY = 2'b10;
   localparam logic [1:0] SEL_STOP   = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                  state_reg;
   logic [DATA_WIDTH-1:0]   shift_reg;
   logic [CNT_W-1:0]        cnt_reg;
   logic                    par_en_reg;
   logic                    ser_data_reg;
   logic                    par_bit_reg;
   logic [1:0]              mux_sel_reg;
   logic                    mux_en_reg;
   logic                    busy_reg;
   logic                    tx_done_reg;

   // Outputs are registered alongside the state so each one reflects the state it belongs to.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         cnt_reg      <= '0;
         par_en_reg   <= 1'b0;
         ser_data_reg <= 1'b0;
         par_bit_reg  <= 1'b0;
         mux_sel_reg  <= SEL_STOP;
         mux_en_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         tx_done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, STOP: begin
               if (DATA_VALID) begin
                  state_reg   <= START;
                  shift_reg   <= P_DATA;
                  par_en_reg  <= PAR_EN;
                  // Parity type is folded in here, so it never needs to be kept.
                  par_bit_reg <= (^P_DATA) ^ PAR_TYP;
                  mux_sel_reg <= SEL_START;
                  mux_en_reg  <= 1'b1;
                  busy_reg    <= 1'b1;
                  tx_done_reg <= 1'b0;
               end else begin
                  state_reg   <= IDLE;
                  mux_sel_reg <= SEL_STOP;
                  mux_en_reg  <= 1'b0;
                  busy_reg    <= 1'b0;
                  tx_done_reg <= 1'b0;
               end
            end
            START: begin
               state_reg    <= DATA;
               cnt_reg      <= '0;
               ser_data_reg <= shift_reg[0];
               shift_reg    <= shift_reg >> 1;
               mux_sel_reg  <= SEL_DATA;
            end
            DATA: begin
               if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
                  if (par_en_reg) begin
                     state_reg   <= PARITY;
                     mux_sel_reg <= SEL_PARITY;
                  end else begin
                     state_reg   <= STOP;
                     mux_sel_reg <= SEL_STOP;
                     tx_done_reg <= 1'b1;
                  end
               end else begin
                  // SER_DATA lags the shift register by one load, so it shows bit cnt+1 next.
                  cnt_reg      <= cnt_reg + CNT_W'(1);
                  ser_data_reg <= shift_reg[0];
                  shift_reg    <= shift_reg >> 1;
               end
            end
            PARITY: begin
               state_reg   <= STOP;
               mux_sel_reg <= SEL_STOP;
               tx_done_reg <= 1'b1;
            end
            default: begin
               state_reg   <= IDLE;
               mux_sel_reg <= SEL_STOP;
               mux_en_reg  <= 1'b0;
               busy_reg    <= 1'b0;
               tx_done_reg <= 1'b0;
            end
         endcase
      end
   end

   assign SER_DATA = ser_data_reg;
   assign PAR_BIT  = par_bit_reg;
   assign MUX_SEL  = mux_sel_reg;
   assign MUX_EN   = mux_en_reg;
   assign BUSY     = busy_reg;
   assign TX_DONE  = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: rebuilds the TX line through a model of the output mux
// and compares every frame cycle against hand-written line patterns.
module tb_uart_tx_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic       ser_data;
   logic       par_bit;
   logic [1:0] mux_sel;
   logic       mux_en;
   logic       busy;
   logic       tx_done;
   logic       tx_line;

   int checks = 0;
   int errors = 0;

   uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
      .CLK        (clk),
      .RST        (rst),
      .P_DATA     (p_data),
      .DATA_VALID (data_valid),
      .PAR_EN     (par_en),
      .PAR_TYP    (par_typ),
      .SER_DATA   (ser_data),
      .PAR_BIT    (par_bit),
      .MUX_SEL    (mux_sel),
      .MUX_EN     (mux_en),
      .BUSY       (busy),
      .TX_DONE    (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External 4:1 mux with enable, as the pin sees it.
   always_comb begin
      tx_line = 1'b1;
      if (mux_en) begin
         case (mux_sel)
            2'b00:   tx_line = 1'b0;
            2'b01:   tx_line = ser_data;
            2'b10:   tx_line = par_bit;
            default: tx_line = 1'b1;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_frame(input logic [7:0] data, input logic pe, input logic pt);
      @(negedge clk);
      p_data     = data;
      par_en     = pe;
      par_typ    = pt;
      data_valid = 1'b1;
   endtask

   // exp_line holds the line bits with cycle 0 in the MSB of the frame length.
   // After sampling cycle 0 the inputs are scrambled (or set up for a following frame).
   task automatic check_frame(input string name, input logic [15:0] exp_line, input logic pe,
                              input int ncyc, input logic release_dv, input logic [7:0] next_data,
                              input logic next_pe, input logic next_pt, input int glitch_at);
      int len;
      logic [1:0] exp_sel;
      len = pe ? 11 : 10;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (i == 0) exp_sel = 2'b00;
         else if (i <= 8) exp_sel = 2'b01;
         else if (i == 9 && pe) exp_sel = 2'b10;
         else exp_sel = 2'b11;
         check($sformatf("%s line[%0d]", name, i), 32'(tx_line), 32'(exp_line[len-1-i]));
         check($sformatf("%s sel[%0d]", name, i), 32'(mux_sel), 32'(exp_sel));
         check($sformatf("%s en[%0d]", name, i), 32'(mux_en), 32'd1);
         check($sformatf("%s busy[%0d]", name, i), 32'(busy), 32'd1);
         check($sformatf("%s done[%0d]", name, i), 32'(tx_done), 32'(i == len - 1));
         if (i == 0) begin
            if (release_dv) data_valid = 1'b0;
            p_data  = next_data;
            par_en  = next_pe;
            par_typ = next_pt;
         end
         if (i == glitch_at) begin
            data_valid = 1'b1;
            p_data     = 8'h00;
         end else if (glitch_at >= 0 && i == glitch_at + 1) begin
            data_valid = 1'b0;
         end
      end
      $display("frame %s checked %0d cycles", name, ncyc);
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      check({name, " en"}, 32'(mux_en), 32'd0);
      check({name, " sel"}, 32'(mux_sel), 32'd3);
      check({name, " busy"}, 32'(busy), 32'd0);
      check({name, " done"}, 32'(tx_done), 32'd0);
      check({name, " line"}, 32'(tx_line), 32'd1);
   endtask

   initial begin
      rst        = 1'b1;
      p_data     = 8'h00;
      data_valid = 1'b0;
      par_en     = 1'b0;
      par_typ    = 1'b0;

      @(negedge clk);
      check("rst ser", 32'(ser_data), 32'd0);
      check("rst par", 32'(par_bit), 32'd0);
      check("rst sel", 32'(mux_sel), 32'd3);
      check("rst en", 32'(mux_en), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(tx_done), 32'd0);
      rst = 1'b0;
      check_idle("idle0");

      // A5 even parity: 0 | 1,0,1,0,0,1,0,1 | 0 | 1
      start_frame(8'hA5, 1'b1, 1'b0);
      check_frame("a5_even", 16'b01010010101, 1'b1, 11, 1'b1, 8'h3C, 1'b0, 1'b1, -1);
      check_idle("idle1");

      // A5 odd parity: parity bit 1
      start_frame(8'hA5, 1'b1, 1'b1);
      check_frame("a5_odd", 16'b01010010111, 1'b1, 11, 1'b1, 8'h00, 1'b0, 1'b0, -1);
      check_idle("idle2");

      // FF even parity: parity bit 0
      start_frame(8'hFF, 1'b1, 1'b0);
      check_frame("ff_even", 16'b01111111101, 1'b1, 11, 1'b1, 8'h81, 1'b0, 1'b1, -1);
      check_idle("idle3");

      // 3C without parity: 0 | 0,0,1,1,1,1,0,0 | 1
      start_frame(8'h3C, 1'b0, 1'b0);
      check_frame("3c_nopar", 16'b0001111001, 1'b0, 10, 1'b1, 8'hFF, 1'b1, 1'b1, -1);
      check_idle("idle4");

      // Back-to-back with DATA_VALID held: 55 then AA, even parity
      start_frame(8'h55, 1'b1, 1'b0);
      check_frame("b2b_55", 16'b01010101001, 1'b1, 11, 1'b0, 8'hAA, 1'b1, 1'b0, -1);
      check_frame("b2b_aa", 16'b00101010101, 1'b1, 11, 1'b1, 8'h00, 1'b0, 1'b1, -1);
      check_idle("idle5");

      // DATA_VALID pulse with 00 during data bit 2 must be ignored
      start_frame(8'hA5, 1'b1, 1'b0);
      check_frame("a5_glitch", 16'b01010010101, 1'b1, 11, 1'b1, 8'hA5, 1'b1, 1'b0, 3);
      check_idle("idle6");

      // Async reset between edges while data bit 3 is on the line
      start_frame(8'hA5, 1'b1, 1'b0);
      check_frame("a5_abort", 16'b01010010101, 1'b1, 5, 1'b1, 8'h00, 1'b0, 1'b0, -1);
      #2 rst = 1'b1;
      #1;
      check("arst en", 32'(mux_en), 32'd0);
      check("arst busy", 32'(busy), 32'd0);
      check("arst sel", 32'(mux_sel), 32'd3);
      check("arst done", 32'(tx_done), 32'd0);
      check("arst line", 32'(tx_line), 32'd1);
      #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) check_idle($sformatf("post_rst%0d", k));

      // Recovery: normal frame after the abort
      start_frame(8'h3C, 1'b0, 1'b0);
      check_frame("3c_after", 16'b0001111001, 1'b0, 10, 1'b1, 8'h00, 1'b1, 1'b0, -1);
      check_idle("idle7");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
